// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//   Stall / flush controller for the 5-stage pipeline. Handles the hazards the
//   forwarding network cannot: load-use (one bubble), multi-cycle data memory
//   (full freeze with a wait-timeout watchdog) and taken branches resolved in
//   EX/MEM (flush of the younger wrong-path stages).
//
// Parameters
//   MAX_WAIT : consecutive not-ready memory cycles tolerated before timeout
//   CNT_W    : width of the wait counter and of the statistics counters
//
// Ports
//   clk, arst_n               : clock, synchronous active-low reset
//   register_addr1/2_ID       : rs1 / rs2 of the instruction in ID
//   uses_rs2_ID               : ID instruction reads rs2
//   register_rd_IDEX          : destination of the instruction in ID/EX
//   memread_IDEX              : ID/EX instruction is a load
//   mem_req_EXMEM, mem_ready  : data memory access in EX/MEM and its handshake
//   branch_taken_EXMEM        : branch resolved taken in EX/MEM
//   pc_write, ifid_write, idex_write, exmem_write : stage write enables
//   idex_bubble               : inject NOP control into ID/EX
//   ifid_flush, idex_flush, exmem_flush           : stage clears
//   mem_error                 : sticky memory-timeout flag
//   stall_cycles, flush_events: statistics counters (HAZARD_STATS_EN only)
//
// Optional feature: define HAZARD_STATS_EN to add the saturating statistics
// counters stall_cycles and flush_events.
// -----------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       register_addr1_ID,
  input  logic [4:0]       register_addr2_ID,
  input  logic             uses_rs2_ID,
  input  logic [4:0]       register_rd_IDEX,
  input  logic             memread_IDEX,
  input  logic             mem_req_EXMEM,
  input  logic             mem_ready,
  input  logic             branch_taken_EXMEM,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
`endif
  output logic             mem_error
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_error_q, mem_error_d;

  logic mem_wait, load_use;

  // ERROR ignores the memory handshake entirely; it is frozen regardless.
  assign mem_wait = (state_q != ERROR) && mem_req_EXMEM && !mem_ready;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = memread_IDEX && (register_rd_IDEX != 5'd0) &&
                    ((register_rd_IDEX == register_addr1_ID) ||
                     (uses_rs2_ID && (register_rd_IDEX == register_addr2_ID)));

  // State register
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Next-state logic. The count is checked before incrementing, so the
  // freeze covers counts 0..MAX_WAIT-1, i.e. exactly MAX_WAIT cycles.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          if (wait_cnt_q >= CNT_W'(MAX_WAIT - 1)) begin
            state_d     = ERROR;
            mem_error_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  // Output logic, priority: error/memory freeze > branch flush > load-use.
  // While reset is asserted the idle defaults are presented.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (arst_n) begin
      if (state_q == ERROR || mem_wait) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
      end else if (branch_taken_EXMEM) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  assign mem_error = mem_error_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (!pc_write && stall_cycles_q != '1)
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (exmem_flush && flush_events_q != '1)
        flush_events_q <= flush_events_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic arst_n;
  logic [4:0] rs1, rs2, rd;
  logic uses_rs2, memread, mem_req, mem_ready, branch;
  logic pc_write, ifid_write, idex_write, exmem_write, idex_bubble;
  logic ifid_flush, idex_flush, exmem_flush, mem_error;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

  hazard_control_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .register_addr1_ID(rs1), .register_addr2_ID(rs2), .uses_rs2_ID(uses_rs2),
    .register_rd_IDEX(rd), .memread_IDEX(memread),
    .mem_req_EXMEM(mem_req), .mem_ready(mem_ready), .branch_taken_EXMEM(branch),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
`ifdef HAZARD_STATS_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: number of consecutive frozen cycles so far and a sticky
  // error bit; statistics as plain integers.
  int run_len = 0;
  bit err_m   = 1'b0;
  int st_m    = 0;
  int fl_m    = 0;

  // Expected output vector:
  // {pc, ifid, idex, exmem, bubble, ifid_fl, idex_fl, exmem_fl, mem_error}
  function automatic logic [8:0] model_out();
    bit lu;
    lu = memread && rd != 0 && (rd == rs1 || (uses_rs2 && rd == rs2));
    if (!arst_n)                    return {4'b1111, 1'b0, 3'b000, err_m};
    if (err_m)                      return {4'b0000, 1'b0, 3'b000, 1'b1};
    if (mem_req && !mem_ready)      return {4'b0000, 1'b0, 3'b000, 1'b0};
    if (branch)                     return {4'b1111, 1'b0, 3'b111, 1'b0};
    if (lu)                         return {4'b0011, 1'b1, 3'b000, 1'b0};
    return {4'b1111, 1'b0, 3'b000, 1'b0};
  endfunction

  task automatic step(input string tag);
    logic [8:0] exp, obs;
    #1;
    exp = model_out();
    obs = {pc_write, ifid_write, idex_write, exmem_write, idex_bubble,
           ifid_flush, idex_flush, exmem_flush, mem_error};
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
`ifdef HAZARD_STATS_EN
    checks++;
    assert (stall_cycles === CNT_W'(st_m) && flush_events === CNT_W'(fl_m)) passed++;
    else $error("FAIL %s_stats: observed %0d/%0d expected %0d/%0d",
                tag, stall_cycles, flush_events, st_m, fl_m);
`endif
    @(posedge clk);
    if (!arst_n) begin
      run_len = 0; err_m = 1'b0; st_m = 0; fl_m = 0;
    end else begin
      if (!exp[8]) st_m++;
      if (exp[1])  fl_m++;
      if (!err_m) begin
        if (mem_req && !mem_ready) begin
          run_len++;
          if (run_len == MAX_WAIT) err_m = 1'b1;
        end else run_len = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rd = 0; uses_rs2 = 0; memread = 0;
    mem_req = 0; mem_ready = 1; branch = 0;
  endtask

  initial begin
    arst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    step("reset0");
    step("reset1");
    arst_n = 1'b1;
    step("idle");

    // load-use on rs1, then the load moves on
    memread = 1; rd = 5; rs1 = 5;
    step("lu_rs1");
    memread = 0;
    step("lu_rs1_after");

    // x0 and unused rs2 never stall; used rs2 does
    memread = 1; rd = 0; rs1 = 0;
    step("lu_x0");
    rd = 7; rs1 = 3; rs2 = 7; uses_rs2 = 0;
    step("lu_rs2_unused");
    uses_rs2 = 1;
    step("lu_rs2_used");
    idle_inputs();

    // three-cycle memory wait then release
    mem_req = 1; mem_ready = 0;
    step("mw1"); step("mw2"); step("mw3");
    mem_ready = 1;
    step("mw_release");
    mem_req = 0;
    step("mw_after");

    // timeout: counter starts from 0 again, 4 frozen cycles then ERROR
    mem_req = 1; mem_ready = 0;
    step("to1"); step("to2"); step("to3"); step("to4");
    step("to_error");
    mem_ready = 1;
    step("to_ready_ignored");
    mem_req = 0;
    step("to_hold");
    arst_n = 0;
    step("to_reset");
    arst_n = 1;
    step("to_recovered");

    // branch overrides load-use
    branch = 1; memread = 1; rd = 9; rs1 = 9;
    step("br_lu");
    idle_inputs();

    // memory wait with branch: freeze, then flush on release
    mem_req = 1; mem_ready = 0; branch = 1;
    step("mw_br1"); step("mw_br2");
    mem_ready = 1;
    step("mw_br_release");
    idle_inputs();

    // reset in the middle of a wait clears the wait count
    mem_req = 1; mem_ready = 0;
    step("rst_mw1"); step("rst_mw2"); step("rst_mw3");
    arst_n = 0;
    step("rst_mw_reset");
    arst_n = 1;
    step("rst_mw_a"); step("rst_mw_b"); step("rst_mw_c"); step("rst_mw_d");
    step("rst_mw_err");
    arst_n = 0;
    step("rst_final");
    arst_n = 1;
    idle_inputs();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      arst_n    = ($urandom_range(0, 39) != 0);
      rs1       = 5'($urandom_range(0, 3));
      rs2       = 5'($urandom_range(0, 3));
      rd        = 5'($urandom_range(0, 3));
      uses_rs2  = 1'($urandom_range(0, 1));
      memread   = 1'($urandom_range(0, 1));
      mem_req   = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      branch    = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
